memory_arbiter: RTL
===================

# memory_arbiter

Shares the single instruction/data main memory port between the instruction cache and the data cache. Each cache sees a private memory-like interface (request level, 28-bit block address, 128-bit block data, busywait). The arbiter serialises their block transfers onto the shared memory port with a three-state FSM. It sits between the two caches and `instruction_memory`/`data_memory` in the `cpu` top level.

## Interface
Parameters: none. Widths are fixed: block address 28 bits, block data 128 bits.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- RESET  in  1  asynchronous, active-high reset
- I_READ  in  1  instruction cache block read request; held until I_BUSYWAIT low
- I_ADDRESS  in  28  instruction block address
- I_READDATA  out  128  block data to the instruction cache; direct copy of MEM_READDATA
- I_BUSYWAIT  out  1  stall to the instruction cache
- D_READ  in  1  data cache block read request
- D_WRITE  in  1  data cache block write-back request
- D_ADDRESS  in  28  data block address
- D_WRITEDATA  in  128  write-back block
- D_READDATA  out  128  block data to the data cache; direct copy of MEM_READDATA
- D_BUSYWAIT  out  1  stall to the data cache
- MEM_READ, MEM_WRITE  out  1 each  shared memory commands
- MEM_ADDRESS  out  28  shared memory block address
- MEM_WRITEDATA  out  128  shared memory write block
- MEM_READDATA  in  128  shared memory read block
- MEM_BUSYWAIT  in  1  shared memory stall

## Operation
- States: IDLE, SERVE_I, SERVE_D. Registers: STATE, SEEN_BUSY (1 b), LAST_GRANT (1 b; 0=I, 1=D).
- Request signals: REQ_I = I_READ; REQ_D = D_READ | D_WRITE. If D_READ and D_WRITE are both high, the write is performed and the read is ignored.
- IDLE: if exactly one request is pending, go to that requester's SERVE state. If both are pending, the winner is selected per Configuration. With no request, stay in IDLE.
- SERVE_x drives MEM_ADDRESS from x and asserts the matching command (MEM_READ, or MEM_WRITE with MEM_WRITEDATA = D_WRITEDATA). Outside SERVE states, the MEM_* commands are 0 and the address/data outputs are 0.
- SEEN_BUSY is cleared on SERVE entry. It is set on any edge in SERVE where MEM_BUSYWAIT = 1.
- DONE = SERVE_x & SEEN_BUSY & ~MEM_BUSYWAIT. It is combinational.
- On the edge where DONE = 1: return to IDLE, set LAST_GRANT to x, and clear SEEN_BUSY.
- Busywait rule: x_BUSYWAIT = REQ_x & ~(SERVE_x & DONE). It is combinational, so a requester is stalled from the first cycle its request appears.
- Read data is broadcast to both requesters. It is valid only in the DONE cycle of the granted requester.
- If a requester drops its request while being served, the transfer still completes. The memory protocol cannot abort.
- Reset (asynchronous, any state): STATE = IDLE, SEEN_BUSY = 0, LAST_GRANT = 1 (so I wins the first round-robin tie). All MEM_* outputs read 0. x_BUSYWAIT follows REQ_x, so it is 1 if x is requesting.

## Timing
- Arbitration latency: a request sampled in IDLE at edge N gives the MEM command high from edge N to N+1.
- Memory contract: the memory asserts MEM_BUSYWAIT at the first edge after seeing a command. It holds MEM_BUSYWAIT until data is ready, then deasserts with MEM_READDATA valid.
- The requester's busywait falls in the same cycle as MEM_BUSYWAIT falls. The requester samples data at the next edge, and the arbiter leaves SERVE at that same edge.
- The minimum gap between back-to-back grants is one IDLE cycle.
- Total per transfer = 1 (IDLE) + memory latency + 1 (DONE cycle).
- There is no combinational path from I_* to D_* outputs or the reverse, except through STATE.

## Configuration
- `MEMORY_ARBITER_ROUND_ROBIN_EN` defined: on simultaneous requests in IDLE, grant the requester that is not LAST_GRANT. Alternation guarantees neither cache waits more than one foreign transfer.
- Not defined: fixed priority, where the data cache always wins ties. LAST_GRANT is still maintained but does not affect the choice.

## Test plan
- Isolated I read: I_READ=1, I_ADDRESS=28'h0000004, memory latency 5 cycles. MEM_READ high 1 cycle after the request. I_BUSYWAIT falls with MEM_BUSYWAIT. I_READDATA equals the memory block. D_BUSYWAIT stays 0.
- Isolated D write-back: D_WRITE=1, D_ADDRESS=28'h0000010, D_WRITEDATA=128'hDEADBEEF_0000_0001. MEM_WRITE high with that address and data until DONE. A read-back via I_READ at 28'h0000010 returns the same block.
- Simultaneous requests from reset: I_READ and D_READ asserted together. With the macro, I is served first, then D. Without it, D is served first, then I. The losing busywait stays high throughout.
- Round-robin fairness (macro on): both requests held continuously for 4 transfers. Grants alternate I, D, I, D.
- D_READ and D_WRITE both high: only MEM_WRITE is asserted. MEM_READ stays 0.
- RESET pulsed mid SERVE_D, 2 cycles into the memory latency: MEM_WRITE and MEM_READ drop to 0 immediately (asynchronously). STATE returns to IDLE. D_BUSYWAIT stays 1 while D_READ is held, and the request is re-arbitrated after reset is released.

Source files
------------

// File: rtl/memory_arbiter.sv
// Arbitrates the shared main-memory port between the instruction and data caches.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin ties; default is data-cache priority.
module memory_arbiter (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         I_READ,
    input  logic [27:0]  I_ADDRESS,
    output logic [127:0] I_READDATA,
    output logic         I_BUSYWAIT,
    input  logic         D_READ,
    input  logic         D_WRITE,
    input  logic [27:0]  D_ADDRESS,
    input  logic [127:0] D_WRITEDATA,
    output logic [127:0] D_READDATA,
    output logic         D_BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   seen_busy_q, seen_busy_d;
    logic   last_grant_q, last_grant_d;
    logic   d_wr_q, d_wr_d;

    logic req_i, req_d;
    logic serving, done, tie_to_d;

    assign req_i    = I_READ;
    assign req_d    = D_READ | D_WRITE;
    assign serving  = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign done     = serving & seen_busy_q & ~MEM_BUSYWAIT;
    // Round robin hands a tie to whoever was not served last; fixed priority favours D.
    assign tie_to_d = RR_EN ? ~last_grant_q : 1'b1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            seen_busy_q  <= 1'b0;
            last_grant_q <= 1'b1;
            d_wr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            seen_busy_q  <= seen_busy_d;
            last_grant_q <= last_grant_d;
            d_wr_q       <= d_wr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        seen_busy_d  = seen_busy_q;
        last_grant_d = last_grant_q;
        d_wr_d       = d_wr_q;
        unique case (state_q)
            IDLE: begin
                if (req_i && req_d) begin
                    state_d = tie_to_d ? SERVE_D : SERVE_I;
                end else if (req_d) begin
                    state_d = SERVE_D;
                end else if (req_i) begin
                    state_d = SERVE_I;
                end
                // The write/read choice is frozen at grant so a dropped request cannot change the command.
                if (req_i || req_d) begin
                    seen_busy_d = 1'b0;
                    d_wr_d      = D_WRITE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (done) begin
                    state_d      = IDLE;
                    last_grant_d = (state_q == SERVE_D);
                    seen_busy_d  = 1'b0;
                end else if (MEM_BUSYWAIT) begin
                    seen_busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (state_q)
            SERVE_I: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = I_ADDRESS;
            end
            SERVE_D: begin
                MEM_ADDRESS = D_ADDRESS;
                if (d_wr_q) begin
                    MEM_WRITE     = 1'b1;
                    MEM_WRITEDATA = D_WRITEDATA;
                end else begin
                    MEM_READ = 1'b1;
                end
            end
            default: begin
                MEM_READ = 1'b0;
            end
        endcase
    end

    assign I_BUSYWAIT = req_i & ~((state_q == SERVE_I) & done);
    assign D_BUSYWAIT = req_d & ~((state_q == SERVE_D) & done);
    assign I_READDATA = MEM_READDATA;
    assign D_READDATA = MEM_READDATA;

endmodule
